// File: rtl/mem_sched_pkg.sv
// Shared types and helpers for the memory port scheduler.
// Range checking in the scheduler is enabled by defining MEM_SCHED_RANGE_CHECK_EN.
package mem_sched_pkg;

  localparam logic TGT_IMEM = 1'b0;
  localparam logic TGT_DMEM = 1'b1;

  typedef struct packed {
    logic        target;
    logic [31:0] addr;
    logic [31:0] wdata;
  } wr_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  // True when the word index of a byte address lies inside a memory of 'words' entries.
  function automatic logic word_in_range(input logic [31:0] addr, input logic [31:0] words);
    return ({2'b00, addr[31:2]} < words);
  endfunction

endpackage

// File: rtl/sync_wr_fifo.sv
// Synchronous FIFO of loader write requests with full/empty flags and a registered count.
module sync_wr_fifo
  import mem_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  wr_req_t                  data_i,
  input  logic                     pop_i,
  output wr_req_t                  data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wr_req_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign pop_ok  = pop_i & ~empty_o;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok = push_i & (~full_o | pop_ok);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/mem_port_scheduler.sv
// Shares imem/dmem port A between the core, buffered loader writes and a zero-fill engine.
// Define MEM_SCHED_RANGE_CHECK_EN to skip out-of-range writes and flag them on err_o.
module mem_port_scheduler
  import mem_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int IMEM_WORDS = 1024,
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_frozen_i,
  input  logic [31:0] core_imem_addr_i,
  input  logic [31:0] core_dmem_addr_i,
  input  logic [31:0] core_dmem_wdata_i,
  input  logic [3:0]  core_dmem_we_i,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  input  logic        ld_target_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_wdata_i,
  input  logic        clr_start_i,
  input  logic        clr_target_i,
  input  logic [31:0] clr_base_i,
  input  logic [15:0] clr_words_i,
  output logic        clr_busy_o,
  output logic        clr_done_o,
  output logic        freeze_req_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        imem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_we_o,
  output logic        err_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  sched_state_e  state_q, state_d;
  wr_req_t       fifo_din, fifo_dout;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW-1:0] fifo_count;

  logic          clr_pend_q, clr_pend_d;
  logic          clr_tgt_q;
  logic [31:0]   clr_base_q;
  logic [15:0]   clr_words_q;
  logic [15:0]   clr_idx_q, clr_idx_d;
  logic          clr_accept;
  logic [31:0]   clr_addr;

  logic          freeze_q, freeze_d;
  logic          err_q;

  logic          cand_tgt;
  logic [31:0]   cand_addr, cand_data;
  logic          cand_ok;
  logic          int_active, wr_fire, err_set;

  assign fifo_din  = {ld_target_i, ld_addr_i, ld_wdata_i};
  assign fifo_push = ld_valid_i & ~fifo_full;

  sync_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (fifo_din),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign ld_ready_o   = ~fifo_full;
  assign clr_busy_o   = clr_pend_q | (state_q == CLEAR);
  assign clr_done_o   = (state_q == DONE);
  assign freeze_req_o = freeze_q;
  assign err_o        = err_q;
  assign clr_accept   = clr_start_i & ~clr_busy_o;
  assign clr_addr     = (clr_base_q & 32'hFFFF_FFFC) + {14'd0, clr_idx_q, 2'b00};

  // Write candidate for the current internal owner.
  always_comb begin
    if (state_q == CLEAR) begin
      cand_tgt  = clr_tgt_q;
      cand_addr = clr_addr;
      cand_data = 32'h0000_0000;
    end else begin
      cand_tgt  = fifo_dout.target;
      cand_addr = fifo_dout.addr;
      cand_data = fifo_dout.wdata;
    end
  end

`ifdef MEM_SCHED_RANGE_CHECK_EN
  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);
  localparam logic [31:0] DMEM_LIMIT = 32'(DMEM_WORDS);
  assign cand_ok = (cand_tgt == TGT_IMEM) ? word_in_range(cand_addr, IMEM_LIMIT)
                                          : word_in_range(cand_addr, DMEM_LIMIT);
`else
  assign cand_ok = 1'b1;
`endif

  // Internal requesters own the ports only while the core is frozen; reset aborts at once.
  assign int_active = rst_ni & core_frozen_i &
                      (((state_q == DRAIN) & ~fifo_empty) | (state_q == CLEAR));
  assign wr_fire    = int_active & cand_ok;
  assign err_set    = int_active & ~cand_ok;

  // Scheduler next-state.
  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    clr_pend_d = clr_pend_q | clr_accept;
    clr_idx_d  = clr_idx_q;
    case (state_q)
      IDLE: begin
        if (core_frozen_i && clr_pend_q) begin
          clr_pend_d = 1'b0;
          clr_idx_d  = 16'd0;
          state_d    = (clr_words_q == 16'd0) ? DONE : CLEAR;
        end else if (core_frozen_i && !fifo_empty) begin
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (core_frozen_i && !fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ((fifo_count == CW'(1)) && !fifo_push) ? IDLE : DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (!core_frozen_i) begin
          state_d = CLEAR;
        end else if (clr_idx_q == (clr_words_q - 16'd1)) begin
          state_d = DONE;
        end else begin
          clr_idx_d = clr_idx_q + 16'd1;
          state_d   = CLEAR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stays asserted one cycle past the return to IDLE so the core never races a last write.
  assign freeze_d = fifo_push | clr_accept | ~fifo_empty | clr_pend_q | (state_q != IDLE);

  // Scheduler registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      clr_pend_q  <= 1'b0;
      clr_tgt_q   <= TGT_IMEM;
      clr_base_q  <= 32'h0000_0000;
      clr_words_q <= 16'd0;
      clr_idx_q   <= 16'd0;
      freeze_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_pend_q <= clr_pend_d;
      clr_idx_q  <= clr_idx_d;
      freeze_q   <= freeze_d;
      err_q      <= err_q | err_set;
      if (clr_accept) begin
        clr_tgt_q   <= clr_target_i;
        clr_base_q  <= clr_base_i;
        clr_words_q <= clr_words_i;
      end
    end
  end

  // Port A multiplexing.
  always_comb begin
    imem_addr_o  = core_imem_addr_i;
    imem_wdata_o = 32'h0000_0000;
    imem_we_o    = 1'b0;
    dmem_addr_o  = core_dmem_addr_i;
    dmem_wdata_o = core_dmem_wdata_i;
    dmem_we_o    = core_dmem_we_i;
    if (int_active) begin
      dmem_we_o = 4'h0;
      if (wr_fire && (cand_tgt == TGT_IMEM)) begin
        imem_addr_o  = cand_addr;
        imem_wdata_o = cand_data;
        imem_we_o    = 1'b1;
      end else if (wr_fire) begin
        dmem_addr_o  = cand_addr;
        dmem_wdata_o = cand_data;
        dmem_we_o    = 4'hF;
      end else begin
        imem_we_o = 1'b0;
      end
    end else begin
      dmem_we_o = core_dmem_we_i;
    end
  end

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed self-checking bench for mem_port_scheduler (default parameters).
module tb_mem_port_scheduler;
  import mem_sched_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_frozen_i;
  logic [31:0] core_imem_addr_i, core_dmem_addr_i, core_dmem_wdata_i;
  logic [3:0]  core_dmem_we_i;
  logic        ld_valid_i, ld_ready_o, ld_target_i;
  logic [31:0] ld_addr_i, ld_wdata_i;
  logic        clr_start_i, clr_target_i;
  logic [31:0] clr_base_i;
  logic [15:0] clr_words_i;
  logic        clr_busy_o, clr_done_o, freeze_req_o;
  logic [31:0] imem_addr_o, imem_wdata_o, dmem_addr_o, dmem_wdata_o;
  logic        imem_we_o, err_o;
  logic [3:0]  dmem_we_o;

  int checks = 0;
  int failures = 0;

  logic        tgt_tab  [8];
  logic [31:0] addr_tab [8];
  logic [31:0] data_tab [8];
  int          nw, ndone;

  always #5 clk_i = ~clk_i;

  mem_port_scheduler dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .core_frozen_i(core_frozen_i),
    .core_imem_addr_i(core_imem_addr_i), .core_dmem_addr_i(core_dmem_addr_i),
    .core_dmem_wdata_i(core_dmem_wdata_i), .core_dmem_we_i(core_dmem_we_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_target_i(ld_target_i),
    .ld_addr_i(ld_addr_i), .ld_wdata_i(ld_wdata_i),
    .clr_start_i(clr_start_i), .clr_target_i(clr_target_i), .clr_base_i(clr_base_i),
    .clr_words_i(clr_words_i), .clr_busy_o(clr_busy_o), .clr_done_o(clr_done_o),
    .freeze_req_o(freeze_req_o),
    .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o), .imem_we_o(imem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_we_o(dmem_we_o),
    .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tgt_tab[0] = TGT_DMEM; addr_tab[0] = 32'h10; data_tab[0] = 32'hDEAD_BEEF;
    tgt_tab[1] = TGT_IMEM; addr_tab[1] = 32'h04; data_tab[1] = 32'h0000_0013;
    for (int i = 2; i < 8; i++) begin
      tgt_tab[i] = TGT_DMEM; addr_tab[i] = 32'h20 + 32'(4 * i); data_tab[i] = 32'(i);
    end

    rst_ni = 1'b0; core_frozen_i = 1'b0;
    core_imem_addr_i = 32'h200; core_dmem_addr_i = 32'h300;
    core_dmem_wdata_i = 32'h55; core_dmem_we_i = 4'h3;
    ld_valid_i = 1'b0; ld_target_i = 1'b0; ld_addr_i = 32'h0; ld_wdata_i = 32'h0;
    clr_start_i = 1'b0; clr_target_i = 1'b0; clr_base_i = 32'h0; clr_words_i = 16'd0;

    // Reset state
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_ld_ready", ld_ready_o, 1'b1);
    chk("rst_busy", clr_busy_o, 1'b0);
    chk("rst_done", clr_done_o, 1'b0);
    chk("rst_freeze", freeze_req_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_imem_addr", imem_addr_o, 32'h200);
    chk("rst_imem_we", imem_we_o, 1'b0);
    chk("rst_imem_wdata", imem_wdata_o, 32'h0);
    chk("rst_dmem_addr", dmem_addr_o, 32'h300);
    chk("rst_dmem_wdata", dmem_wdata_o, 32'h55);
    chk("rst_dmem_we", dmem_we_o, 4'h3);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fill the FIFO while the core runs
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      ld_valid_i = 1'b1; ld_target_i = tgt_tab[k];
      ld_addr_i = addr_tab[k]; ld_wdata_i = data_tab[k];
      #1;
      chk("fill_ready", ld_ready_o, 1'b1);
      if (k == 0) chk("freeze_before_push", freeze_req_o, 1'b0);
      if (k == 1) chk("freeze_after_push", freeze_req_o, 1'b1);
      chk("fill_passthru_we", dmem_we_o, 4'h3);
    end
    @(negedge clk_i);
    ld_valid_i = 1'b0;
    #1;
    chk("full_ready", ld_ready_o, 1'b0);
    chk("full_passthru_addr", dmem_addr_o, 32'h300);
    chk("full_imem_we", imem_we_o, 1'b0);

    // Freeze the core and drain in order
    @(negedge clk_i);
    core_frozen_i = 1'b1; core_dmem_we_i = 4'h0;
    #1;
    chk("idle_frozen_dmem_we", dmem_we_o, 4'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      #1;
      if (tgt_tab[k] == TGT_IMEM) begin
        chk("drain_imem_we", imem_we_o, 1'b1);
        chk("drain_imem_addr", imem_addr_o, addr_tab[k]);
        chk("drain_imem_wdata", imem_wdata_o, data_tab[k]);
        chk("drain_imem_other", dmem_we_o, 4'h0);
      end else begin
        chk("drain_dmem_we", dmem_we_o, 4'hF);
        chk("drain_dmem_addr", dmem_addr_o, addr_tab[k]);
        chk("drain_dmem_wdata", dmem_wdata_o, data_tab[k]);
        chk("drain_dmem_other", imem_we_o, 1'b0);
      end
      if (k == 1) chk("drain_ready", ld_ready_o, 1'b1);
    end
    @(negedge clk_i);
    #1;
    chk("drain_end_freeze", freeze_req_o, 1'b1);
    chk("drain_end_dmem_we", dmem_we_o, 4'h0);
    chk("drain_end_imem_we", imem_we_o, 1'b0);
    @(negedge clk_i);
    #1;
    chk("freeze_drop", freeze_req_o, 1'b0);

    // Clear dmem 0x100, 3 words; a second start while running is ignored
    @(negedge clk_i);
    clr_start_i = 1'b1; clr_target_i = TGT_DMEM; clr_base_i = 32'h100; clr_words_i = 16'd3;
    #1;
    chk("clr_busy_pre", clr_busy_o, 1'b0);
    @(negedge clk_i);
    clr_start_i = 1'b0;
    #1;
    chk("clr_busy", clr_busy_o, 1'b1);
    chk("clr_freeze", freeze_req_o, 1'b1);
    chk("clr_idle_we", dmem_we_o, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      if (i == 0) begin
        clr_start_i = 1'b1; clr_words_i = 16'd7; clr_base_i = 32'h500;
      end else begin
        clr_start_i = 1'b0;
      end
      #1;
      chk("clr_we", dmem_we_o, 4'hF);
      chk("clr_addr", dmem_addr_o, 32'h100 + 32'(4 * i));
      chk("clr_wdata", dmem_wdata_o, 32'h0);
      chk("clr_done_early", clr_done_o, 1'b0);
    end
    @(negedge clk_i);
    clr_start_i = 1'b0;
    #1;
    chk("clr_done", clr_done_o, 1'b1);
    chk("clr_busy_fall", clr_busy_o, 1'b0);
    chk("clr_done_we", dmem_we_o, 4'h0);
    @(negedge clk_i);
    #1;
    chk("clr_done_pulse", clr_done_o, 1'b0);
    chk("clr_restart_ignored", clr_busy_o, 1'b0);

    // Clear imem with unaligned base and a 2-cycle unfreeze in the middle
    core_imem_addr_i = 32'h400;
    @(negedge clk_i);
    clr_start_i = 1'b1; clr_target_i = TGT_IMEM; clr_base_i = 32'h203; clr_words_i = 16'd5;
    @(negedge clk_i);
    clr_start_i = 1'b0;
    nw = 0; ndone = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk_i);
      core_frozen_i = (j == 2 || j == 3) ? 1'b0 : 1'b1;
      #1;
      if (j == 2) begin
        chk("pause_no_write", imem_we_o, 1'b0);
        chk("pause_passthru", imem_addr_o, 32'h400);
        chk("pause_busy", clr_busy_o, 1'b1);
      end
      if (imem_we_o === 1'b1) begin
        chk("pause_addr_seq", imem_addr_o, 32'h200 + 32'(4 * nw));
        chk("pause_wdata", imem_wdata_o, 32'h0);
        nw++;
      end
      if (clr_done_o === 1'b1) ndone++;
    end
    chk("pause_write_count", 32'(nw), 32'd5);
    chk("pause_done_count", 32'(ndone), 32'd1);

    // Zero-length clear
    @(negedge clk_i);
    clr_start_i = 1'b1; clr_target_i = TGT_DMEM; clr_base_i = 32'h0; clr_words_i = 16'd0;
    @(negedge clk_i);
    clr_start_i = 1'b0;
    #1;
    chk("zero_done_early", clr_done_o, 1'b0);
    chk("zero_dmem_we", dmem_we_o, 4'h0);
    @(negedge clk_i);
    #1;
    chk("zero_done", clr_done_o, 1'b1);
    chk("zero_dmem_we2", dmem_we_o, 4'h0);
    chk("zero_imem_we", imem_we_o, 1'b0);
    @(negedge clk_i);
    #1;
    chk("zero_done_pulse", clr_done_o, 1'b0);

    // Clear requested during DRAIN starts after the FIFO empties
    @(negedge clk_i);
    core_frozen_i = 1'b0;
    ld_valid_i = 1'b1; ld_target_i = TGT_DMEM; ld_addr_i = 32'h40; ld_wdata_i = 32'h1111_1111;
    @(negedge clk_i);
    ld_addr_i = 32'h44; ld_wdata_i = 32'h2222_2222;
    @(negedge clk_i);
    ld_valid_i = 1'b0; core_frozen_i = 1'b1;
    #1;
    chk("d2c_idle_we", dmem_we_o, 4'h0);
    @(negedge clk_i);
    clr_start_i = 1'b1; clr_target_i = TGT_DMEM; clr_base_i = 32'h80; clr_words_i = 16'd1;
    #1;
    chk("d2c_first_addr", dmem_addr_o, 32'h40);
    chk("d2c_first_data", dmem_wdata_o, 32'h1111_1111);
    @(negedge clk_i);
    clr_start_i = 1'b0;
    #1;
    chk("d2c_second_addr", dmem_addr_o, 32'h44);
    chk("d2c_second_we", dmem_we_o, 4'hF);
    @(negedge clk_i);
    #1;
    chk("d2c_gap_we", dmem_we_o, 4'h0);
    chk("d2c_gap_busy", clr_busy_o, 1'b1);
    @(negedge clk_i);
    #1;
    chk("d2c_clr_we", dmem_we_o, 4'hF);
    chk("d2c_clr_addr", dmem_addr_o, 32'h80);
    chk("d2c_clr_wdata", dmem_wdata_o, 32'h0);
    @(negedge clk_i);
    #1;
    chk("d2c_done", clr_done_o, 1'b1);

    // Out-of-range loader write (word index 1024 of a 1024-word imem)
    @(negedge clk_i);
    ld_valid_i = 1'b1; ld_target_i = TGT_IMEM; ld_addr_i = 32'h1000; ld_wdata_i = 32'hABCD;
    #1;
    chk("range_err_pre", err_o, 1'b0);
    @(negedge clk_i);
    ld_valid_i = 1'b0;
    @(negedge clk_i);
    #1;
`ifdef MEM_SCHED_RANGE_CHECK_EN
    chk("range_skip_we", imem_we_o, 1'b0);
    @(negedge clk_i);
    #1;
    chk("range_err_set", err_o, 1'b1);
    @(negedge clk_i);
    #1;
    chk("range_err_sticky", err_o, 1'b1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    #1;
    chk("range_err_cleared", err_o, 1'b0);
    rst_ni = 1'b1;
`else
    chk("oob_write_we", imem_we_o, 1'b1);
    chk("oob_write_addr", imem_addr_o, 32'h1000);
    @(negedge clk_i);
    #1;
    chk("oob_err_low", err_o, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
